// File: rtl/logic_shift_unit.sv
// Bitwise logic and bit-serial shift/rotate unit with valid/ready handshakes on both sides.
// Rotate opcodes are built only when LOGIC_SHIFT_ROTATE_EN is defined; otherwise they flag illegal.
module logic_shift_unit #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    input  logic [2:0]         opsel,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               cout,
    output logic               zero,
    output logic               illegal
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q;
    logic               illegal_q;
    logic               cin_q;
    logic [1:0]         shift_op_q;
    logic [SHAMT_W-1:0] cnt_q;

    logic [WIDTH-1:0]   logic_result;
    logic [WIDTH-1:0]   step_result;
    logic               step_cout;

    always_comb begin
        logic_result = '0;
        case (opsel[1:0])
            2'b00:   logic_result = op1 & op2;
            2'b01:   logic_result = op1 | op2;
            2'b10:   logic_result = op1 ^ op2;
            default: logic_result = ~op1;
        endcase
    end

    // One bit of shift/rotate per SHIFT cycle; cout tracks the bit leaving the word.
    always_comb begin
        step_result = result_q;
        step_cout   = cout_q;
        case (shift_op_q)
            2'b00: begin
                step_result = {result_q[WIDTH-2:0], cin_q};
                step_cout   = result_q[WIDTH-1];
            end
            2'b01: begin
                step_result = {cin_q, result_q[WIDTH-1:1]};
                step_cout   = result_q[0];
            end
`ifdef LOGIC_SHIFT_ROTATE_EN
            2'b10: begin
                step_result = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
                step_cout   = result_q[WIDTH-1];
            end
            2'b11: begin
                step_result = {result_q[0], result_q[WIDTH-1:1]};
                step_cout   = result_q[0];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            result_q   <= '0;
            cout_q     <= 1'b0;
            illegal_q  <= 1'b0;
            cin_q      <= 1'b0;
            shift_op_q <= 2'b00;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        cout_q     <= 1'b0;
                        illegal_q  <= 1'b0;
                        cin_q      <= cin;
                        shift_op_q <= opsel[1:0];
                        if (!opsel[2]) begin
                            result_q <= logic_result;
                            state_q  <= StDone;
                        end
`ifndef LOGIC_SHIFT_ROTATE_EN
                        else if (opsel[1]) begin
                            result_q  <= '0;
                            illegal_q <= 1'b1;
                            state_q   <= StDone;
                        end
`endif
                        else begin
                            result_q <= op1;
                            cnt_q    <= shamt;
                            state_q  <= (shamt == '0) ? StDone : StShift;
                        end
                    end
                end
                StShift: begin
                    result_q <= step_result;
                    cout_q   <= step_cout;
                    cnt_q    <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign cout      = cout_q;
    assign illegal   = illegal_q;
    assign zero      = (result_q == '0);

endmodule

// File: tb/tb_logic_shift_unit.sv
// Self-checking bench for logic_shift_unit (WIDTH=8): vector table, scoreboard, corner sequences.
// Expectations for opcodes 110/111 follow LOGIC_SHIFT_ROTATE_EN.
module tb_logic_shift_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] op1 = '0;
    logic [7:0] op2 = '0;
    logic [2:0] opsel = '0;
    logic [2:0] shamt = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       cout;
    logic       zero;
    logic       illegal;

    logic_shift_unit #(
        .WIDTH   (8),
        .SHAMT_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .opsel     (opsel),
        .shamt     (shamt),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] op1;
        logic [7:0] op2;
        logic [2:0] opsel;
        logic [2:0] shamt;
        logic       cin;
        logic [7:0] res;
        logic       cout;
        logic       ill;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       cout;
        logic       zero;
        logic       ill;
        int         lat;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                                input logic [2:0] sh, input logic c, input logic [7:0] res,
                                input logic co, input logic ill, input int lat);
        vec_t v;
        v.op1 = a; v.op2 = b; v.opsel = sel; v.shamt = sh; v.cin = c;
        v.res = res; v.cout = co; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    task automatic drive(input string tag, input vec_t v);
        exp_t e;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        op1 = v.op1; op2 = v.op2; opsel = v.opsel; shamt = v.shamt; cin = v.cin;
        in_valid = 1'b1;
        e.res = v.res; e.cout = v.cout; e.zero = (v.res == 8'h00); e.ill = v.ill; e.lat = v.lat;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int   lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: out_valid low after %0d cycles, expected within %0d",
                     tag, lat, e.lat);
        end else begin
            check({tag, "_latency"}, 32'(lat), 32'(e.lat));
            check({tag, "_result"}, 32'(result), 32'(e.res));
            check({tag, "_cout"}, 32'(cout), 32'(e.cout));
            check({tag, "_zero"}, 32'(zero), 32'(e.zero));
            check({tag, "_illegal"}, 32'(illegal), 32'(e.ill));
            check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        end
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int   seen;
        vec_t v;

        // Reset state, observed while rst is still high.
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);

        //                 op1    op2    sel     sh    cin   res    cout  ill  lat
        tbl.push_back(mk(8'hF0, 8'h3C, 3'b000, 3'd5, 1'b0, 8'h30, 1'b0, 1'b0, 1));
        tbl.push_back(mk(8'hF0, 8'h0F, 3'b001, 3'd3, 1'b1, 8'hFF, 1'b0, 1'b0, 1));
        tbl.push_back(mk(8'hAA, 8'hAA, 3'b010, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1));
        tbl.push_back(mk(8'h5A, 8'h00, 3'b011, 3'd7, 1'b0, 8'hA5, 1'b0, 1'b0, 1));
        tbl.push_back(mk(8'h81, 8'h00, 3'b100, 3'd3, 1'b1, 8'h0F, 1'b0, 1'b0, 4));
        tbl.push_back(mk(8'h01, 8'h00, 3'b101, 3'd1, 1'b0, 8'h00, 1'b1, 1'b0, 2));
        tbl.push_back(mk(8'h81, 8'h00, 3'b100, 3'd0, 1'b1, 8'h81, 1'b0, 1'b0, 1));
        tbl.push_back(mk(8'h80, 8'h00, 3'b101, 3'd7, 1'b0, 8'h01, 1'b0, 1'b0, 8));
        tbl.push_back(mk(8'hC3, 8'h00, 3'b101, 3'd2, 1'b1, 8'hF0, 1'b1, 1'b0, 3));
        tbl.push_back(mk(8'h40, 8'h00, 3'b100, 3'd2, 1'b0, 8'h00, 1'b1, 1'b0, 3));
`ifdef LOGIC_SHIFT_ROTATE_EN
        tbl.push_back(mk(8'h81, 8'h00, 3'b110, 3'd1, 1'b0, 8'h03, 1'b1, 1'b0, 2));
        tbl.push_back(mk(8'h01, 8'h00, 3'b111, 3'd3, 1'b0, 8'h20, 1'b0, 1'b0, 4));
        tbl.push_back(mk(8'h96, 8'h00, 3'b110, 3'd0, 1'b0, 8'h96, 1'b0, 1'b0, 1));
`else
        tbl.push_back(mk(8'h81, 8'h00, 3'b110, 3'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1));
        tbl.push_back(mk(8'h01, 8'h00, 3'b111, 3'd3, 1'b0, 8'h00, 1'b0, 1'b1, 1));
        tbl.push_back(mk(8'h96, 8'h00, 3'b110, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1));
`endif

        foreach (tbl[i]) begin
            drive($sformatf("v%0d", i), tbl[i]);
            collect($sformatf("v%0d", i));
            release_out($sformatf("v%0d", i));
        end

        // Backpressure: result holds and new requests are dropped while DONE waits.
        drive("bp", tbl[0]);
        collect("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            op1 = 8'($urandom);
            opsel = 3'b011;
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_result%0d", i), 32'(result), 32'h30);
            check($sformatf("bp_hold_in_ready%0d", i), 32'(in_ready), 32'd0);
            check($sformatf("bp_hold_out_valid%0d", i), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        release_out("bp");
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        check("bp_pulses_ignored", 32'(seen), 32'd0);

        // Reset in the middle of a long shift discards the operation.
        @(negedge clk);
        op1 = 8'hFF; opsel = 3'b100; shamt = 3'd7; cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        check("midrst_no_output", 32'(seen), 32'd0);

        drive("recover", tbl[4]);
        collect("recover");
        release_out("recover");

        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected to end sooner",
                 $time);
        $fatal(1);
    end

endmodule

// File: doc/logic_shift_unit.md
LOGIC_SHIFT_UNIT -- requirements
Module: logic_shift_unit

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; SHALL be a power of two, at least 2.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  the operation on op1/op2/opsel/shamt/cin is valid.
REQ-006 in_ready  output  1  the unit accepts an operation this cycle.
REQ-007 op1, op2  input  WIDTH  operands.
REQ-008 opsel  input  3  operation select: 000 AND, 001 OR, 010 XOR, 011 NOT op1, 100 SHL, 101 SHR, 110 ROL, 111 ROR.
REQ-009 shamt  input  SHAMT_W  shift/rotate amount, in bits.
REQ-010 cin  input  1  fill bit shifted into the vacated position by SHL/SHR.
REQ-011 out_valid  output  1  result/cout/zero/illegal are valid.
REQ-012 out_ready  input  1  the consumer takes the result.
REQ-013 result  output  WIDTH  operation result.
REQ-014 cout  output  1  last bit shifted or rotated out; 0 for logic ops and for shamt=0.
REQ-015 zero  output  1  high when result equals 0.
REQ-016 illegal  output  1  the opcode is not supported in this build.

Function
REQ-017 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-018 IDLE: in_ready=1 and out_valid=0; in_valid=1 SHALL latch all inputs (accept).
REQ-019 Logic op accept: result SHALL be registered, with a transition to DONE; out_valid rises the cycle after accept (latency 1).
REQ-020 Shift/rotate accept with shamt=0: next state DONE, result=op1, cout=0.
REQ-021 Shift/rotate accept with shamt>0: next state SHIFT, step counter=shamt.
REQ-022 SHIFT: one bit per cycle; counter decrements; on the step where the counter reaches 0, next state DONE; total latency is 1+shamt cycles.
REQ-023 SHL step: result={result[WIDTH-2:0],cin}, cout=result[WIDTH-1]; SHR step: result={cin,result[WIDTH-1:1]}, cout=result[0].
REQ-024 ROL/ROR steps SHALL rotate, with cout equal to the bit moved across the boundary.
REQ-025 DONE: out_valid=1; result/cout/zero/illegal held stable until out_ready=1, then next state IDLE.
REQ-026 in_ready=0 in SHIFT and DONE; in_valid SHALL be ignored there, with no queuing.
REQ-027 An operation cannot be accepted in the same cycle that out_ready is taken; back-to-back throughput is one op per 2+shamt cycles.
REQ-028 zero SHALL be combinational from the registered result.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, result=0, cout=0, illegal=0, out_valid=0 and counter=0.
REQ-030 zero SHALL read 1 during reset, since result=0.
REQ-031 Reset mid-SHIFT or mid-DONE SHALL discard the operation with no output produced.
REQ-032 in_ready=1 from the first cycle after rst deasserts.

Configuration
REQ-033 Macro LOGIC_SHIFT_ROTATE_EN defined: ROL/ROR (110/111) execute per REQ-024, and illegal stays 0.
REQ-034 Macro absent: opcodes 110/111 SHALL complete with latency 1, result=0, cout=0, illegal=1, and no rotate logic synthesised.

Verification (WIDTH=8)
REQ-035 AND: op1=0xF0, op2=0x3C, opsel=000 -> out_valid 1 cycle after accept; result=0x30, cout=0, zero=0.
REQ-036 SHL: op1=0x81, shamt=3, cin=1 -> out_valid 4 cycles after accept; result=0x0F, cout=0.
REQ-037 SHR: op1=0x01, shamt=1, cin=0 -> result=0x00, zero=1, cout=1.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> result stable, in_ready=0, pulses ignored; single out_ready=1 -> IDLE.
REQ-039 Reset mid-op: shamt=7 SHL, assert rst 3 cycles after accept -> out_valid=0 and in_ready=1 asynchronously; no result emitted.
REQ-040 Rotate: op1=0x81, shamt=1, opsel=110 -> with macro: result=0x03, cout=1, illegal=0; without macro: result=0x00, illegal=1, latency 1.
